filtro_iir_secuencial: RTL

Time-multiplexed second-order recursive (biquad) filter stage computing y[n] = b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2] in signed Q7.14. It drives one instance of the team's saturating fixed-point multiplier (Multiplicador_Filtro) with operand pairs and consumes its products in a saturating accumulator. It holds the x/y delay lines and the sequencing FSM. It sits between the sample source (ADC interface) and the output sink (DAC interface).

---
 rtl/filtro_pkg.sv | 26 ++
 rtl/filtro_iir_secuencial_if.sv | 30 +++
 rtl/Multiplicador_Filtro.sv | 31 +++
 rtl/sumador_sat.sv | 26 ++
 rtl/filtro_iir_secuencial.sv | 105 ++++++++++
 5 files changed

// File: rtl/filtro_pkg.sv
// Shared definitions for the recursive filter stages: Q7.14 word format,
// symmetric saturation limits and the sequencing FSM encoding.
package filtro_pkg;

    localparam int Width     = 22;
    localparam int Presicion = 14;

    localparam int MAXIMO_INT = (1 << (Width - 1)) - 1;

    localparam logic signed [Width-1:0] MAXIMO = Width'(MAXIMO_INT);
    localparam logic signed [Width-1:0] MINIMO = -MAXIMO;
    // Same limits one bit wider, for comparing unclamped sums.
    localparam logic signed [Width:0]   MAX_EXT = (Width + 1)'(MAXIMO_INT);
    localparam logic signed [Width:0]   MIN_EXT = -MAX_EXT;

    localparam logic signed [Width-1:0] UNO = Width'(1 << Presicion);

    typedef logic signed [Width-1:0] muestra_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MAC       = 2'd1,
        ACTUALIZA = 2'd2
    } estado_t;

endpackage

// File: rtl/filtro_iir_secuencial_if.sv
// Sample/result bus between the sample source, the filter stage and the sink.
// Handshake: a sample transfers on a rising edge where muestra_valid=1 and listo=1;
// with listo=0 muestra_valid is ignored (nothing is held). y_valid pulses for one
// cycle when y_out carries a new result; there is no back-pressure on the output.
interface filtro_iir_secuencial_if;
    import filtro_pkg::*;

    muestra_t muestra_in;
    logic     muestra_valid;
    logic     listo;
    muestra_t y_out;
    logic     y_valid;

    modport master (
        output muestra_in,
        output muestra_valid,
        input  listo,
        input  y_out,
        input  y_valid
    );

    modport slave (
        input  muestra_in,
        input  muestra_valid,
        output listo,
        output y_out,
        output y_valid
    );

endinterface

// File: rtl/Multiplicador_Filtro.sv
// Saturating Q7.14 multiplier: full product rescaled by arithmetic shift
// (truncation toward minus infinity), then clamped to the symmetric range.
module Multiplicador_Filtro
    import filtro_pkg::*;
(
    input  muestra_t a_i,
    input  muestra_t b_i,
    output muestra_t p_o
);

    logic signed [2*Width-1:0] prod_full;
    logic signed [2*Width-1:0] prod_sh;
    logic        [Width:0]     prod_hi;
    logic                      en_rango;

    assign prod_full = a_i * b_i;
    assign prod_sh   = prod_full >>> Presicion;
    assign prod_hi   = prod_sh[2*Width-1:Width-1];
    assign en_rango  = (&prod_hi) | ~(|prod_hi);

    always_comb begin
        p_o = prod_sh[Width-1:0];
        if (!en_rango) begin
            p_o = prod_sh[2*Width-1] ? MINIMO : MAXIMO;
        end else if (p_o == {1'b1, {(Width-1){1'b0}}}) begin
            // The most negative code is outside the symmetric range.
            p_o = MINIMO;
        end
    end

endmodule

// File: rtl/sumador_sat.sv
// Saturating Width-bit adder/subtractor, computed one bit wider and clamped
// to the symmetric range [MINIMO, MAXIMO].
module sumador_sat
    import filtro_pkg::*;
(
    input  muestra_t a_i,
    input  muestra_t b_i,
    input  logic     resta_i,
    output muestra_t s_o
);

    logic signed [Width:0] suma;

    assign suma = resta_i ? ({a_i[Width-1], a_i} - {b_i[Width-1], b_i})
                          : ({a_i[Width-1], a_i} + {b_i[Width-1], b_i});

    always_comb begin
        s_o = suma[Width-1:0];
        if (suma > MAX_EXT) begin
            s_o = MAXIMO;
        end else if (suma < MIN_EXT) begin
            s_o = MINIMO;
        end
    end

endmodule

// File: rtl/filtro_iir_secuencial.sv
// Time-multiplexed biquad stage: one multiplier and one saturating accumulator
// evaluate the five terms over five cycles, then the delay lines shift.
module filtro_iir_secuencial
    import filtro_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    filtro_iir_secuencial_if.slave  bus,
    input  muestra_t                b0,
    input  muestra_t                b1,
    input  muestra_t                b2,
    input  muestra_t                a1,
    input  muestra_t                a2,
    output estado_t                 estado_o
);

    estado_t    estado_q;
    logic [2:0] k_q;
    muestra_t   x0_q, x1_q, x2_q, y1_q, y2_q;
    muestra_t   acc_q, y_out_q;
    logic       y_valid_q;

    muestra_t   op_coef, op_dato, producto, acc_d;
    logic       resta;

    // k selects the term; feedback terms (k=3,4) are subtracted.
    always_comb begin
        op_coef = '0;
        op_dato = '0;
        case (k_q)
            3'd0: begin op_coef = b0; op_dato = x0_q; end
            3'd1: begin op_coef = b1; op_dato = x1_q; end
            3'd2: begin op_coef = b2; op_dato = x2_q; end
            3'd3: begin op_coef = a1; op_dato = y1_q; end
            3'd4: begin op_coef = a2; op_dato = y2_q; end
            default: begin op_coef = '0; op_dato = '0; end
        endcase
    end

    assign resta = (k_q >= 3'd3);

    Multiplicador_Filtro u_mult (
        .a_i (op_coef),
        .b_i (op_dato),
        .p_o (producto)
    );

    sumador_sat u_acc (
        .a_i     (acc_q),
        .b_i     (producto),
        .resta_i (resta),
        .s_o     (acc_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_q  <= IDLE;
            k_q       <= '0;
            x0_q      <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            y1_q      <= '0;
            y2_q      <= '0;
            acc_q     <= '0;
            y_out_q   <= '0;
            y_valid_q <= 1'b0;
        end else begin
            y_valid_q <= 1'b0;
            case (estado_q)
                IDLE: begin
                    if (bus.muestra_valid) begin
                        x0_q     <= bus.muestra_in;
                        acc_q    <= '0;
                        k_q      <= '0;
                        estado_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (k_q == 3'd4) begin
                        estado_q <= ACTUALIZA;
                    end else begin
                        k_q <= k_q + 3'd1;
                    end
                end
                ACTUALIZA: begin
                    y_out_q   <= acc_q;
                    x2_q      <= x1_q;
                    x1_q      <= x0_q;
                    y2_q      <= y1_q;
                    y1_q      <= acc_q;
                    y_valid_q <= 1'b1;
                    estado_q  <= IDLE;
                end
                default: estado_q <= IDLE;
            endcase
        end
    end

    assign bus.listo   = (estado_q == IDLE);
    assign bus.y_out   = y_out_q;
    assign bus.y_valid = y_valid_q;
    assign estado_o    = estado_q;

endmodule
